// File: rtl/seqgen_pkg.sv
// Shared types and constants for the seqgen serial pattern transmitter.
package seqgen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_GAP   = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  localparam logic [4:0] PAT_10001 = 5'b10001;

endpackage

// File: rtl/seqgen_tx_if.sv
// Control/data bundle between the controlling logic (master) and seqgen_tx (slave).
interface seqgen_tx_if #(
  parameter int WIDTH = 5,
  parameter int REPW  = 4,
  parameter int GAPW  = 4
);
  import seqgen_pkg::*;

  // start is a level request sampled on the rising edge; it is accepted only when
  // busy is low (IDLE) and abort is low. busy rises the cycle after accept and
  // stays high through the single-cycle done pulse; valid qualifies dout.
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [REPW-1:0]  reps;
  logic [GAPW-1:0]  gap;
  logic             abort;
  logic             dout;
  logic             valid;
  logic             busy;
  logic             done;
  state_t           state;

  modport master (
    output start, pattern, reps, gap, abort,
    input  dout, valid, busy, done, state
  );

  modport slave (
    input  start, pattern, reps, gap, abort,
    output dout, valid, busy, done, state
  );

endinterface

// File: rtl/piso_shift.sv
// Parallel-load, serial-out shift register; msb reports the MSB the register
// will hold after the current edge so the caller can register it alongside.
module piso_shift #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_nxt;

  always_comb begin
    q_nxt = q;
    if (load) begin
      q_nxt = din;
    end else if (shift_en) begin
      q_nxt = {q[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = q_nxt[WIDTH-1];

  always_ff @(posedge clk) begin
    if (!clr) begin
      q <= '0;
    end else begin
      q <= q_nxt;
    end
  end

endmodule

// File: rtl/seqgen_tx.sv
// Serial pattern transmitter: sends a captured pattern MSB-first, repeated with
// optional idle gaps, under a start/busy/done handshake with abort.
module seqgen_tx
  import seqgen_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int REPW  = 4,
  parameter int GAPW  = 4
) (
  input logic        clk,
  input logic        clr,
  seqgen_tx_if.slave bus
);

  localparam int BITW = $clog2(WIDTH);
  localparam logic [BITW-1:0] BIT_LAST = BITW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [BITW-1:0]  bit_cnt, bit_cnt_nxt;
  logic [REPW-1:0]  rep_cnt, rep_cnt_nxt;
  logic [GAPW-1:0]  gap_cnt, gap_cnt_nxt;
  logic [WIDTH-1:0] pat_q;
  logic [GAPW-1:0]  gap_q;
  logic [WIDTH-1:0] load_data;
  logic             accept;
  logic             load;
  logic             shift_en;
  logic             sr_msb;
  logic             dout_q, valid_q, busy_q, done_q;

  piso_shift #(.WIDTH(WIDTH)) u_piso (
    .clk      (clk),
    .clr      (clr),
    .load     (load),
    .shift_en (shift_en),
    .din      (load_data),
    .msb      (sr_msb)
  );

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    rep_cnt_nxt = rep_cnt;
    gap_cnt_nxt = gap_cnt;
    accept      = 1'b0;
    load        = 1'b0;
    shift_en    = 1'b0;
    load_data   = pat_q;

    if (bus.abort && state != ST_IDLE) begin
      state_nxt   = ST_IDLE;
      bit_cnt_nxt = '0;
      rep_cnt_nxt = '0;
      gap_cnt_nxt = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start && !bus.abort) begin
            accept      = 1'b1;
            load        = 1'b1;
            load_data   = bus.pattern;
            rep_cnt_nxt = (bus.reps == '0) ? REPW'(1) : bus.reps;
            bit_cnt_nxt = '0;
            gap_cnt_nxt = '0;
            state_nxt   = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt_nxt = '0;
            if (rep_cnt <= REPW'(1)) begin
              state_nxt = ST_DONE;
            end else begin
              // Reload now so the first bit of the next repetition is ready
              // either immediately (no gap) or when the gap expires.
              rep_cnt_nxt = rep_cnt - 1'b1;
              load        = 1'b1;
              if (gap_q != '0) begin
                gap_cnt_nxt = gap_q;
                state_nxt   = ST_GAP;
              end
            end
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
            shift_en    = 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_cnt <= GAPW'(1)) begin
            gap_cnt_nxt = '0;
            state_nxt   = ST_SHIFT;
          end else begin
            gap_cnt_nxt = gap_cnt - 1'b1;
          end
        end
        ST_DONE: begin
          rep_cnt_nxt = '0;
          state_nxt   = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      rep_cnt <= '0;
      gap_cnt <= '0;
      pat_q   <= '0;
      gap_q   <= '0;
      dout_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      rep_cnt <= rep_cnt_nxt;
      gap_cnt <= gap_cnt_nxt;
      if (accept) begin
        pat_q <= bus.pattern;
        gap_q <= bus.gap;
      end
      // Moore outputs decoded from where the FSM and shift register are going.
      dout_q  <= (state_nxt == ST_SHIFT) ? sr_msb : 1'b0;
      valid_q <= (state_nxt == ST_SHIFT);
      busy_q  <= (state_nxt != ST_IDLE);
      done_q  <= (state_nxt == ST_DONE);
    end
  end

  assign bus.dout  = dout_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.state = state;

endmodule

// File: tb/tb_seqgen_tx.sv
// Directed bench for seqgen_tx: per-cycle check against a stream-queue model
// plus hand-computed literal expectations for each scenario.
module tb_seqgen_tx;
  import seqgen_pkg::*;

  localparam int WIDTH = 5;
  localparam int REPW  = 4;
  localparam int GAPW  = 4;
  localparam int W     = 4;  // {dout, valid, busy, done}

  logic clk;
  logic clr;

  seqgen_tx_if #(.WIDTH(WIDTH), .REPW(REPW), .GAPW(GAPW)) bus ();

  seqgen_tx #(.WIDTH(WIDTH), .REPW(REPW), .GAPW(GAPW)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // ---------------- model: expected output stream ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] cur_exp = '0;

  task automatic build_stream(input logic [WIDTH-1:0] pat, input int reps, input int gap);
    int r;
    r = (reps == 0) ? 1 : reps;
    for (int i = 0; i < r; i++) begin
      for (int b = WIDTH - 1; b >= 0; b--) exp_q.push_back({pat[b], 3'b110});
      if (i < r - 1) for (int g = 0; g < gap; g++) exp_q.push_back(4'b0010);
    end
    exp_q.push_back(4'b0011);
  endtask

  always @(posedge clk) begin
    if (!clr) begin
      exp_q.delete();
      cur_exp = '0;
    end else if (bus.abort && cur_exp[1]) begin
      exp_q.delete();
      cur_exp = '0;
    end else if (!cur_exp[1] && bus.start && !bus.abort) begin
      build_stream(bus.pattern, int'(bus.reps), int'(bus.gap));
      cur_exp = exp_q.pop_front();
    end else if (exp_q.size() > 0) begin
      cur_exp = exp_q.pop_front();
    end else begin
      cur_exp = '0;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      if ({bus.dout, bus.valid, bus.busy, bus.done} !== cur_exp ||
          (!cur_exp[1] && bus.state !== ST_IDLE)) begin
        n_err++;
        $display("FAIL cycle_out @%0t: got dout/valid/busy/done=%b state=%0d expected %b (idle when busy=0)",
                 $time, {bus.dout, bus.valid, bus.busy, bus.done}, bus.state, cur_exp);
      end
    end
  end

  // ---------------- transmission monitor ----------------
  int          busy_cnt, nbits, gap_cyc, done_at, done_cnt, det_hits;
  logic [31:0] stream;
  logic [4:0]  det_sr;
  int          hit_pos[3];

  always @(negedge clk) begin
    if (bus.busy === 1'b1) begin
      busy_cnt++;
      if (bus.valid) begin
        stream = {stream[30:0], bus.dout};
        nbits++;
        det_sr = {det_sr[3:0], bus.dout};
        if (det_sr == PAT_10001) begin
          if (det_hits < 3) hit_pos[det_hits] = nbits;
          det_hits++;
        end
      end else if (!bus.done) begin
        gap_cyc++;
      end
      if (bus.done) begin
        done_at = busy_cnt;
        done_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_stats();
    busy_cnt = 0; nbits = 0; gap_cyc = 0; done_at = 0; done_cnt = 0;
    det_hits = 0; stream = '0; det_sr = '0;
    for (int i = 0; i < 3; i++) hit_pos[i] = 0;
  endtask

  task automatic send(input logic [WIDTH-1:0] pat, input logic [REPW-1:0] reps,
                      input logic [GAPW-1:0] gap);
    @(posedge clk); #1;
    clear_stats();
    bus.start = 1'b1; bus.pattern = pat; bus.reps = reps; bus.gap = gap;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_timeout"}, 32'(ok), 32'd1);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    bus.start = 1'b0; bus.pattern = '0; bus.reps = '0; bus.gap = '0; bus.abort = 1'b0;
    clr = 1'b0;
    clear_stats();
    repeat (2) @(posedge clk);
    #1 clr = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_outs", {28'd0, bus.dout, bus.valid, bus.busy, bus.done}, 32'd0);
    check("reset_state", 32'(bus.state), 32'(ST_IDLE));

    // basic single send
    send(PAT_10001, 4'd1, 4'd0);
    wait_idle("basic", 40);
    check("basic_stream", stream & 32'h1f, 32'h11);
    check("basic_busy", busy_cnt, 6);
    check("basic_done_at", done_at, 6);

    // back-to-back with detector loopback
    send(PAT_10001, 4'd3, 4'd0);
    wait_idle("b2b", 60);
    check("b2b_stream", stream & 32'h7fff, 32'b100011000110001);
    check("b2b_gap", gap_cyc, 0);
    check("b2b_busy", busy_cnt, 16);
    check("b2b_hits", det_hits, 3);
    check("b2b_hit_pos", {8'(hit_pos[0]), 8'(hit_pos[1]), 8'(hit_pos[2])}, {8'd5, 8'd10, 8'd15});

    // gap insertion
    send(PAT_10001, 4'd2, 4'd3);
    wait_idle("gap", 60);
    check("gap_stream", stream & 32'h3ff, 32'b1000110001);
    check("gap_cycles", gap_cyc, 3);
    check("gap_busy", busy_cnt, 14);

    // inputs changed mid-transmission are ignored
    send(5'b10110, 4'd2, 4'd1);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.pattern = 5'b11111; bus.reps = 4'd7; bus.gap = 4'd9;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_idle("stable", 60);
    check("stable_stream", stream & 32'h3ff, 32'b1011010110);
    check("stable_busy", busy_cnt, 12);

    // abort on the third bit
    send(5'b11011, 4'd1, 4'd0);
    @(posedge clk); #1;
    @(posedge clk); #1 bus.abort = 1'b1;
    @(posedge clk); #1 bus.abort = 1'b0;
    @(negedge clk);
    check("abort_outs", {28'd0, bus.dout, bus.valid, bus.busy, bus.done}, 32'd0);
    check("abort_bits", nbits, 3);
    check("abort_no_done", done_cnt, 0);

    // abort together with start in IDLE
    @(posedge clk); #1;
    clear_stats();
    bus.start = 1'b1; bus.abort = 1'b1; bus.reps = 4'd1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.abort = 1'b0;
    @(negedge clk);
    check("abort_start_idle", {31'd0, bus.busy}, 32'd0);

    // reps = 0 sends once
    send(5'b10011, 4'd0, 4'd2);
    wait_idle("reps0", 40);
    check("reps0_bits", nbits, 5);
    check("reps0_busy", busy_cnt, 6);

    // reset in the middle of a gap
    send(PAT_10001, 4'd3, 4'd4);
    begin
      bit in_gap;
      in_gap = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (bus.busy && !bus.valid && !bus.done) begin
          in_gap = 1'b1;
          break;
        end
      end
      check("gap_reached", 32'(in_gap), 32'd1);
    end
    @(posedge clk); #1 clr = 1'b0;
    @(posedge clk); #1 clr = 1'b1;
    @(negedge clk);
    check("clr_outs", {28'd0, bus.dout, bus.valid, bus.busy, bus.done}, 32'd0);
    check("clr_state", 32'(bus.state), 32'(ST_IDLE));
    send(5'b10101, 4'd1, 4'd0);
    wait_idle("after_clr", 40);
    check("after_clr_stream", stream & 32'h1f, 32'b10101);
    check("after_clr_busy", busy_cnt, 6);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/seqgen_tx.md
# seqgen_tx

Serial pattern transmitter: the sending end of our serial sequence-detection path. It loads a WIDTH-bit pattern and shifts it out MSB-first on `dout`, one bit per clock. It can repeat the pattern a programmable number of times, with a programmable run of idle zeros between repetitions. Its primary use is to drive the `10001` Moore detector `din` input in the lab bench and on the board, with a start/busy/done handshake toward the controlling logic.

## Interface
- `WIDTH`, 5: pattern length in bits.
- `REPW`, 4: width of the repetition count.
- `GAPW`, 4: width of the inter-repetition gap count.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `clr`  in  1: synchronous, active-low reset. Sampled only on the `clk` rising edge.
- `start`  in  1: request a transmission. Accepted only in IDLE.
- `pattern`  in  WIDTH: bits to send. `pattern[WIDTH-1]` goes first. Captured on start accept.
- `reps`  in  REPW: number of pattern repetitions. Captured on accept. 0 is treated as 1.
- `gap`  in  GAPW: zero-bit cycles inserted between repetitions. Captured on accept.
- `abort`  in  1: terminate the current transmission.
- `dout`  out  1: serial data. Registered.
- `valid`  out  1: high while `dout` carries a pattern bit. Low during gaps and idle.
- `busy`  out  1: high from the cycle after accept through the DONE cycle.
- `done`  out  1: one-cycle pulse on normal completion.

## Operation
- States: IDLE, SHIFT, GAP, DONE.
- IDLE:
  - `start`=1 captures `pattern` into the shift register, `reps` into the rep counter (0→1), and `gap` into the gap reload value.
  - The bit counter is cleared, and the next state is SHIFT.
- SHIFT:
  - Emits the current shift-register MSB and shifts left, filling with 0.
  - The bit counter counts 0..WIDTH-1.
  - On the last bit:
    - If this is the last repetition, go to DONE.
    - Otherwise decrement reps and reload the shift register from the captured pattern copy.
    - Then go to GAP if gap≠0, else directly to SHIFT (back-to-back, no bubble).
- GAP: `dout`=0 and `valid`=0 for exactly `gap` cycles, then SHIFT with the reloaded pattern.
- DONE: `done`=1 and `busy`=1 for one cycle, `dout`=0, then IDLE.
- `abort`=1 in SHIFT, GAP or DONE: next state IDLE, all outputs 0, no `done` pulse.
- Priority: `clr` > `abort` > `start` > normal sequencing.
- `start` in any non-IDLE state is ignored.
- Input changes after accept have no effect on the transmission in progress.
- `abort` together with `start` in IDLE: `start` is ignored and the block stays IDLE.
- Reset values: state IDLE, `dout`=0, `valid`=0, `busy`=0, `done`=0, all counters 0.
- Reset mid-operation: at the next edge with `clr`=0, every output and counter returns to its reset value, with no `done` pulse.

## Timing
- All outputs are registered Moore outputs, decoded from the next state and the next shift-register content.
- Start accepted at edge T: the first bit is on `dout` with `valid`=1 during cycle T+1.
- Bit k of a repetition is on `dout` during cycle T+1+k.
- Total busy cycles: reps·WIDTH + (reps−1)·gap + 1 (the DONE cycle).
- `done` is high in the final busy cycle.
- A new `start` is accepted at the earliest on the edge ending the DONE cycle+1, i.e. in the first IDLE cycle.
- Counter widths:
  - Bit counter: clog2(WIDTH).
  - Rep counter: REPW.
  - Gap counter: GAPW.
  - No wrap-around is permitted; counters stop at their terminal values.

## Structure
- Package `seqgen_pkg` holds:
  - State encoding localparams: ST_IDLE=2'b00, ST_SHIFT=2'b01, ST_GAP=2'b10, ST_DONE=2'b11.
  - Default pattern constant `PAT_10001`=5'b10001.
- One natural sub-module, `piso_shift`:
  - WIDTH-bit parallel-load, serial-out register.
  - Controls: load, shift enable, MSB out.
- The FSM and counters live in `seqgen_tx`.

## Test plan
- Reset, then basic send:
  - Stimulus: hold `clr`=0 for 2 cycles, then `start` with `pattern`=5'b10001, `reps`=1, `gap`=0.
  - Response: `dout`=1,0,0,0,1 in cycles T+1..T+5 with `valid`=1; `done`=1 at T+6; IDLE at T+7.
- Back-to-back with loopback into the detector:
  - Stimulus: `reps`=3, `gap`=0.
  - Response: stream 100011000110001 with `valid` continuously high; detector `dout` pulses three times, 5 cycles apart; `done` at T+16.
- Gap insertion:
  - Stimulus: `reps`=2, `gap`=3.
  - Response: `dout` 10001 000 10001; `valid` low for the 3 gap cycles; `done` at T+14.
- Input stability:
  - Stimulus: during a transmission, pulse `start` and change `pattern` to 5'b11111.
  - Response: both ignored; original bits are completed.
- Abort and reps=0:
  - Stimulus: assert `abort` on the third bit.
  - Response: next cycle all outputs 0, no `done`, IDLE.
  - Stimulus: `start` with `reps`=0.
  - Response: exactly one repetition is sent.
- Reset mid-GAP:
  - Stimulus: drive `clr`=0 during a GAP cycle.
  - Response: next edge gives reset values. A subsequent `start` transmits normally from bit 0.
